multicycle_sequencer: RTL and testbench
=======================================

MULTICYCLE_SEQUENCER -- requirements
Module: multicycle_sequencer

Interface
REQ-001 Parameter WAIT_LIMIT, default 255: maximum cycles the block waits on a memory-ready input before it declares a bus error.
REQ-002 clk  in  1  sole clock; all state updates on the rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 imem_ready  in  1  instruction memory has valid data this cycle.
REQ-005 dm_ready  in  1  data memory has completed the pending read or write this cycle.
REQ-006 RegWrite, MemRead, MemWrite  in  1 each  decoded controls from ControlUnit for the current instruction register (IR) contents.
REQ-007 IsCOP0, ExRegWrite  in  1 each  COP0 instruction flag and COP0 register-write request.
REQ-008 HasExp  in  1  CP0 exception or eret redirect pending.
REQ-009 Halt  in  1  syscall halt request from SyscallDecoder.
REQ-010 pc_we, ir_we, rf_we, dm_re, dm_we  out  1 each  write/read strobes for the PC, IR, register file and data memory.
REQ-011 state  out  3  current state encoding.
REQ-012 halted, bus_err  out  1 each  sticky status flags.
REQ-013 retired  out  32  count of retired instructions.

Function
REQ-014 State encoding SHALL be: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5; codes 6-7 SHALL go to FETCH on the next clock.
REQ-015 FETCH SHALL assert ir_we while imem_ready=1 and go to DECODE; otherwise it SHALL stay in FETCH with ir_we=0.
REQ-016 DECODE SHALL go unconditionally to EXEC with no strobes asserted.
REQ-017 EXEC priority, highest first: HasExp -> pc_we=1, go FETCH; Halt -> go HALT, no pc_we; MemRead|MemWrite -> go MEM; effective write enable -> go WB; else pc_we=1, go FETCH.
REQ-018 Effective write enable SHALL be ExRegWrite when IsCOP0=1, else RegWrite.
REQ-019 MEM SHALL hold dm_re=MemRead and dm_we=MemWrite every cycle until dm_ready=1.
REQ-020 On dm_ready in MEM, a load SHALL go to WB; a store SHALL assert pc_we and go to FETCH in the same cycle.
REQ-021 WB SHALL assert rf_we and pc_we for exactly one cycle, then go to FETCH.
REQ-022 retired SHALL increment by 1 on every cycle with pc_we=1 and wrap from 0xFFFFFFFF to 0.
REQ-023 A wait counter SHALL clear on entry to FETCH or MEM and count each cycle spent waiting there.
REQ-024 If the wait counter reaches WAIT_LIMIT with no ready, the block SHALL set bus_err and go to HALT.
REQ-025 If ready arrives in the same cycle the limit is reached, ready SHALL win and no error SHALL be flagged.
REQ-026 HALT SHALL be absorbing until reset: halted=1, all strobes 0, retired frozen.
REQ-027 pc_we, ir_we, rf_we, dm_re and dm_we SHALL be combinational from state and inputs.
REQ-028 No two of ir_we, rf_we and dm_we SHALL ever be high in the same cycle.
REQ-029 Instruction latencies with zero-wait memory SHALL be: ALU/COP0 4 cycles, load 5, store 4, branch/jump/nop 3.

Reset
REQ-030 While reset=1, state SHALL go to FETCH; retired, the wait counter, halted and bus_err SHALL clear; all strobes SHALL be 0.
REQ-031 Reset asserted mid-MEM SHALL drop dm_re and dm_we in the same cycle, because they decode from state and reset forces the strobes low.
REQ-032 Reset SHALL take priority over every transition, including exit from HALT.

Structure
REQ-033 A shared package mc_seq_pkg SHALL hold the state enum type, its encodings and the WAIT_LIMIT default.
REQ-034 The wait counter and limit compare SHALL live in one sub-module, wait_timer: inputs clear and enable; output expired.
REQ-035 The next-state logic and strobe decode SHALL sit in a single combinational process beside one state register.

Verification
REQ-036 Scenario: add with imem_ready=1 -> states 0,1,2,4 then 0; rf_we high in cycle 4; retired=1.
REQ-037 Scenario: lw with dm_ready low for 2 MEM cycles -> dm_re high for 3 cycles; total latency 7 cycles; rf_we then pc_we in WB.
REQ-038 Scenario: sw with dm_ready=1 -> dm_we high for 1 cycle; pc_we in the same cycle; no rf_we; latency 4 cycles.
REQ-039 Scenario: HasExp=1 and Halt=1 together in EXEC -> pc_we=1, next state FETCH, halted stays 0.
REQ-040 Scenario: WAIT_LIMIT=4 and dm_ready held 0 -> bus_err=1 and state=5 after 4 MEM cycles; retired unchanged.
REQ-041 Scenario: reset pulsed during MEM -> dm_re/dm_we=0 while reset is high; state=0 and retired=0 the next cycle.

Source files
------------

// File: rtl/mc_seq_pkg.sv
// Shared types for the multicycle sequencer: state encoding and wait-limit default.
package mc_seq_pkg;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    HALT   = 3'd5
  } state_t;

  localparam int unsigned WAIT_LIMIT_DEFAULT = 255;

endpackage

// File: rtl/wait_timer.sv
// Counts consecutive cycles spent waiting on a memory-ready input.
// Ports: clk; clear (synchronous zero of the count); enable (waiting this cycle);
// expired (this waiting cycle is the WAIT_LIMIT-th one).
module wait_timer
  import mc_seq_pkg::*;
#(
  parameter int unsigned WAIT_LIMIT = WAIT_LIMIT_DEFAULT
) (
  input  logic clk,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CNT_W = (WAIT_LIMIT < 2) ? 1 : $clog2(WAIT_LIMIT);

  logic [CNT_W-1:0] count;

  // count holds the waits already seen, so the current cycle is number count+1
  assign expired = enable && ((32'(count) + 32'd1) >= 32'(WAIT_LIMIT));

  always_ff @(posedge clk) begin
    if (clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/multicycle_sequencer.sv
// Multicycle CPU control sequencer: FETCH/DECODE/EXEC/MEM/WB with a memory
// wait timeout that raises bus_err and halts.
// Ports: clk, reset (sync, active-high); imem_ready, dm_ready; decoded controls
// RegWrite, MemRead, MemWrite, IsCOP0, ExRegWrite, HasExp, Halt;
// combinational strobes pc_we, ir_we, rf_we, dm_re, dm_we;
// registered state, halted, bus_err, retired.
module multicycle_sequencer
  import mc_seq_pkg::*;
#(
  parameter int unsigned WAIT_LIMIT = WAIT_LIMIT_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        imem_ready,
  input  logic        dm_ready,
  input  logic        RegWrite,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic        IsCOP0,
  input  logic        ExRegWrite,
  input  logic        HasExp,
  input  logic        Halt,
  output logic        pc_we,
  output logic        ir_we,
  output logic        rf_we,
  output logic        dm_re,
  output logic        dm_we,
  output logic [2:0]  state,
  output logic        halted,
  output logic        bus_err,
  output logic [31:0] retired
);

  state_t state_q;
  state_t state_d;
  logic   eff_we;
  logic   wait_en;
  logic   wait_clr;
  logic   expired;

  assign state   = state_q;
  assign eff_we  = IsCOP0 ? ExRegWrite : RegWrite;
  assign wait_en = !reset && (((state_q == FETCH) && !imem_ready) ||
                              ((state_q == MEM) && !dm_ready));
  // Any state change (including reset) restarts the wait count for the next wait state
  assign wait_clr = reset || (state_d != state_q);

  wait_timer #(.WAIT_LIMIT(WAIT_LIMIT)) u_wait_timer (
    .clk     (clk),
    .clear   (wait_clr),
    .enable  (wait_en),
    .expired (expired)
  );

  // State register and sticky status
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FETCH;
      halted  <= 1'b0;
      bus_err <= 1'b0;
      retired <= '0;
    end else begin
      state_q <= state_d;
      if (state_d == HALT) halted <= 1'b1;
      if (expired) bus_err <= 1'b1;
      if (pc_we) retired <= retired + 32'd1;
    end
  end

  // Next-state and strobe decode
  always_comb begin
    state_d = state_q;
    pc_we   = 1'b0;
    ir_we   = 1'b0;
    rf_we   = 1'b0;
    dm_re   = 1'b0;
    dm_we   = 1'b0;
    if (reset) begin
      state_d = FETCH;
    end else begin
      case (state_q)
        FETCH: begin
          if (imem_ready) begin
            ir_we   = 1'b1;
            state_d = DECODE;
          end else if (expired) begin
            state_d = HALT;
          end
        end
        DECODE: state_d = EXEC;
        EXEC: begin
          if (HasExp) begin
            pc_we   = 1'b1;
            state_d = FETCH;
          end else if (Halt) begin
            state_d = HALT;
          end else if (MemRead || MemWrite) begin
            state_d = MEM;
          end else if (eff_we) begin
            state_d = WB;
          end else begin
            pc_we   = 1'b1;
            state_d = FETCH;
          end
        end
        MEM: begin
          dm_re = MemRead;
          dm_we = MemWrite;
          if (dm_ready) begin
            if (MemRead) begin
              state_d = WB;
            end else begin
              pc_we   = 1'b1;
              state_d = FETCH;
            end
          end else if (expired) begin
            state_d = HALT;
          end
        end
        WB: begin
          rf_we   = 1'b1;
          pc_we   = 1'b1;
          state_d = FETCH;
        end
        HALT:    state_d = HALT;
        default: state_d = FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed cycle-by-cycle vectors for multicycle_sequencer (WAIT_LIMIT=4),
// followed by per-instruction-class latency sequences.
module tb_multicycle_sequencer;

  localparam int unsigned LIMIT = 4;

  // control bundle order: {RegWrite, MemRead, MemWrite, IsCOP0, ExRegWrite, HasExp, Halt}
  localparam logic [6:0] C_NOP   = 7'b0000000;
  localparam logic [6:0] C_ALU   = 7'b1000000;
  localparam logic [6:0] C_LW    = 7'b1100000;
  localparam logic [6:0] C_SW    = 7'b0010000;
  localparam logic [6:0] C_C0W   = 7'b0001100;
  localparam logic [6:0] C_C0N   = 7'b1001000;
  localparam logic [6:0] C_EXH   = 7'b0000011;
  localparam logic [6:0] C_HLT   = 7'b0000001;

  // strobe bundle order: {pc_we, ir_we, rf_we, dm_re, dm_we}
  localparam logic [4:0] Z   = 5'b00000;
  localparam logic [4:0] IW  = 5'b01000;
  localparam logic [4:0] PW  = 5'b10000;
  localparam logic [4:0] WBS = 5'b10100;
  localparam logic [4:0] DR  = 5'b00010;
  localparam logic [4:0] DW  = 5'b00001;
  localparam logic [4:0] SWP = 5'b10001;

  logic        clk;
  logic        reset;
  logic        imem_ready, dm_ready;
  logic        RegWrite, MemRead, MemWrite, IsCOP0, ExRegWrite, HasExp, Halt;
  logic        pc_we, ir_we, rf_we, dm_re, dm_we;
  logic [2:0]  state;
  logic        halted, bus_err;
  logic [31:0] retired;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic        rst;
    logic        imr;
    logic        dmr;
    logic [6:0]  ctl;
    logic [4:0]  stb;
    logic [2:0]  st;
    logic        hlt;
    logic        berr;
    logic [31:0] ret;
  } vec_t;

  vec_t vecs[$];

  multicycle_sequencer #(.WAIT_LIMIT(LIMIT)) dut (
    .clk(clk), .reset(reset), .imem_ready(imem_ready), .dm_ready(dm_ready),
    .RegWrite(RegWrite), .MemRead(MemRead), .MemWrite(MemWrite),
    .IsCOP0(IsCOP0), .ExRegWrite(ExRegWrite), .HasExp(HasExp), .Halt(Halt),
    .pc_we(pc_we), .ir_we(ir_we), .rf_we(rf_we), .dm_re(dm_re), .dm_we(dm_we),
    .state(state), .halted(halted), .bus_err(bus_err), .retired(retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic rst, input logic imr, input logic dmr,
                              input logic [6:0] ctl, input logic [4:0] stb,
                              input logic [2:0] st, input logic hlt, input logic berr,
                              input logic [31:0] ret);
    vec_t v;
    v.rst = rst; v.imr = imr; v.dmr = dmr; v.ctl = ctl; v.stb = stb;
    v.st = st; v.hlt = hlt; v.berr = berr; v.ret = ret;
    return v;
  endfunction

  task automatic drive(input logic rst, input logic imr, input logic dmr, input logic [6:0] ctl);
    reset = rst;
    imem_ready = imr;
    dm_ready = dmr;
    {RegWrite, MemRead, MemWrite, IsCOP0, ExRegWrite, HasExp, Halt} = ctl;
  endtask

  task automatic check(input string name, input vec_t v);
    logic [41:0] got;
    logic [41:0] exp;
    got = {pc_we, ir_we, rf_we, dm_re, dm_we, state, halted, bus_err, retired};
    exp = {v.stb, v.st, v.hlt, v.berr, v.ret};
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got stb=%b st=%0d halted=%b bus_err=%b retired=%0d, expected stb=%b st=%0d halted=%b bus_err=%b retired=%0d",
               name, got[41:37], got[36:34], got[33], got[32], got[31:0],
               v.stb, v.st, v.hlt, v.berr, v.ret);
    end
    n_cmp++;
    if ((ir_we && rf_we) || (ir_we && dm_we) || (rf_we && dm_we)) begin
      n_bad++;
      $display("FAIL %s exclusive: got ir_we=%b rf_we=%b dm_we=%b, expected at most one high",
               name, ir_we, rf_we, dm_we);
    end
  endtask

  // Cycles from the ir_we cycle up to and including the pc_we cycle
  task automatic measure(input string name, input logic [6:0] ctl, input int exp_lat);
    int  cyc;
    logic done;
    cyc = 0;
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      drive(1'b0, 1'b1, 1'b1, ctl);
      #1;
      cyc++;
      if (pc_we) done = 1'b1;
    end
    n_cmp++;
    if (!done || cyc != exp_lat) begin
      n_bad++;
      $display("FAIL latency %s: got %0d cycles (pc_we seen=%b), expected %0d", name, cyc, done, exp_lat);
    end
  endtask

  initial begin
    // add: F D E WB
    vecs.push_back(mk(1, 1, 0, C_ALU, Z,   0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, C_ALU, IW,  0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, C_ALU, Z,   1, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, C_ALU, Z,   2, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, C_ALU, WBS, 4, 0, 0, 0));
    // lw with two MEM wait cycles
    vecs.push_back(mk(0, 1, 0, C_LW,  IW,  0, 0, 0, 1));
    vecs.push_back(mk(0, 1, 0, C_LW,  Z,   1, 0, 0, 1));
    vecs.push_back(mk(0, 1, 0, C_LW,  Z,   2, 0, 0, 1));
    vecs.push_back(mk(0, 1, 0, C_LW,  DR,  3, 0, 0, 1));
    vecs.push_back(mk(0, 1, 0, C_LW,  DR,  3, 0, 0, 1));
    vecs.push_back(mk(0, 1, 1, C_LW,  DR,  3, 0, 0, 1));
    vecs.push_back(mk(0, 1, 0, C_LW,  WBS, 4, 0, 0, 1));
    // sw zero-wait
    vecs.push_back(mk(0, 1, 1, C_SW,  IW,  0, 0, 0, 2));
    vecs.push_back(mk(0, 1, 1, C_SW,  Z,   1, 0, 0, 2));
    vecs.push_back(mk(0, 1, 1, C_SW,  Z,   2, 0, 0, 2));
    vecs.push_back(mk(0, 1, 1, C_SW,  SWP, 3, 0, 0, 2));
    // COP0 write uses ExRegWrite
    vecs.push_back(mk(0, 1, 0, C_C0W, IW,  0, 0, 0, 3));
    vecs.push_back(mk(0, 1, 0, C_C0W, Z,   1, 0, 0, 3));
    vecs.push_back(mk(0, 1, 0, C_C0W, Z,   2, 0, 0, 3));
    vecs.push_back(mk(0, 1, 0, C_C0W, WBS, 4, 0, 0, 3));
    // COP0 with RegWrite=1 but ExRegWrite=0: no writeback
    vecs.push_back(mk(0, 1, 0, C_C0N, IW,  0, 0, 0, 4));
    vecs.push_back(mk(0, 1, 0, C_C0N, Z,   1, 0, 0, 4));
    vecs.push_back(mk(0, 1, 0, C_C0N, PW,  2, 0, 0, 4));
    // fetch waits two cycles, then nop
    vecs.push_back(mk(0, 0, 0, C_NOP, Z,   0, 0, 0, 5));
    vecs.push_back(mk(0, 0, 0, C_NOP, Z,   0, 0, 0, 5));
    vecs.push_back(mk(0, 1, 0, C_NOP, IW,  0, 0, 0, 5));
    vecs.push_back(mk(0, 1, 0, C_NOP, Z,   1, 0, 0, 5));
    vecs.push_back(mk(0, 1, 0, C_NOP, PW,  2, 0, 0, 5));
    // lw: ready on the 4th MEM cycle (limit cycle) wins
    vecs.push_back(mk(0, 1, 0, C_LW,  IW,  0, 0, 0, 6));
    vecs.push_back(mk(0, 1, 0, C_LW,  Z,   1, 0, 0, 6));
    vecs.push_back(mk(0, 1, 0, C_LW,  Z,   2, 0, 0, 6));
    vecs.push_back(mk(0, 1, 0, C_LW,  DR,  3, 0, 0, 6));
    vecs.push_back(mk(0, 1, 0, C_LW,  DR,  3, 0, 0, 6));
    vecs.push_back(mk(0, 1, 0, C_LW,  DR,  3, 0, 0, 6));
    vecs.push_back(mk(0, 1, 1, C_LW,  DR,  3, 0, 0, 6));
    vecs.push_back(mk(0, 1, 0, C_LW,  WBS, 4, 0, 0, 6));
    // HasExp beats Halt in EXEC
    vecs.push_back(mk(0, 1, 0, C_EXH, IW,  0, 0, 0, 7));
    vecs.push_back(mk(0, 1, 0, C_EXH, Z,   1, 0, 0, 7));
    vecs.push_back(mk(0, 1, 0, C_EXH, PW,  2, 0, 0, 7));
    vecs.push_back(mk(0, 1, 0, C_NOP, IW,  0, 0, 0, 8));
    vecs.push_back(mk(0, 1, 0, C_NOP, Z,   1, 0, 0, 8));
    vecs.push_back(mk(0, 1, 0, C_NOP, PW,  2, 0, 0, 8));
    // reset during a store's MEM wait
    vecs.push_back(mk(0, 1, 0, C_SW,  IW,  0, 0, 0, 9));
    vecs.push_back(mk(0, 1, 0, C_SW,  Z,   1, 0, 0, 9));
    vecs.push_back(mk(0, 1, 0, C_SW,  Z,   2, 0, 0, 9));
    vecs.push_back(mk(0, 1, 0, C_SW,  DW,  3, 0, 0, 9));
    vecs.push_back(mk(1, 1, 0, C_SW,  Z,   3, 0, 0, 9));
    vecs.push_back(mk(0, 1, 0, C_ALU, IW,  0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, C_ALU, Z,   1, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, C_ALU, Z,   2, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, C_ALU, WBS, 4, 0, 0, 0));
    // lw MEM timeout after 4 waits -> bus_err, HALT absorbing
    vecs.push_back(mk(0, 1, 0, C_LW,  IW,  0, 0, 0, 1));
    vecs.push_back(mk(0, 1, 0, C_LW,  Z,   1, 0, 0, 1));
    vecs.push_back(mk(0, 1, 0, C_LW,  Z,   2, 0, 0, 1));
    vecs.push_back(mk(0, 1, 0, C_LW,  DR,  3, 0, 0, 1));
    vecs.push_back(mk(0, 1, 0, C_LW,  DR,  3, 0, 0, 1));
    vecs.push_back(mk(0, 1, 0, C_LW,  DR,  3, 0, 0, 1));
    vecs.push_back(mk(0, 1, 0, C_LW,  DR,  3, 0, 0, 1));
    vecs.push_back(mk(0, 1, 1, C_ALU, Z,   5, 1, 1, 1));
    vecs.push_back(mk(0, 1, 1, C_EXH, Z,   5, 1, 1, 1));
    vecs.push_back(mk(1, 1, 1, C_EXH, Z,   5, 1, 1, 1));
    // fetch timeout
    vecs.push_back(mk(0, 0, 0, C_NOP, Z,   0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, C_NOP, Z,   0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, C_NOP, Z,   0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, C_NOP, Z,   0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, C_NOP, Z,   5, 1, 1, 0));
    vecs.push_back(mk(1, 1, 0, C_NOP, Z,   5, 1, 1, 0));
    // syscall halt: no pc_we, no bus_err
    vecs.push_back(mk(0, 1, 0, C_HLT, IW,  0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, C_HLT, Z,   1, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, C_HLT, Z,   2, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, C_HLT, Z,   5, 1, 0, 0));
    vecs.push_back(mk(0, 1, 1, C_ALU, Z,   5, 1, 0, 0));

    drive(1'b1, 1'b0, 1'b0, C_NOP);
    repeat (2) @(posedge clk);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i].rst, vecs[i].imr, vecs[i].dmr, vecs[i].ctl);
      #1;
      check($sformatf("vec[%0d]", i), vecs[i]);
    end

    // Zero-wait latency per instruction class, starting fresh from reset
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b1, C_NOP);
    measure("alu",  C_ALU, 4);
    measure("cop0", C_C0W, 4);
    measure("load", C_LW,  5);
    measure("store", C_SW, 4);
    measure("nop",  C_NOP, 3);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b1, C_NOP);
    #1;
    check("retired_after_latency", mk(0, 0, 1, C_NOP, Z, 0, 0, 0, 5));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
